// File: rtl/chacha_pkg.sv
// Shared ChaCha block/word types, serializer state encoding and word select.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package chacha_pkg;

  localparam int CHACHA_WORD_W      = 32;
  localparam int CHACHA_BLOCK_WORDS = 16;
  localparam int CHACHA_BLOCK_W     = CHACHA_WORD_W * CHACHA_BLOCK_WORDS;
  localparam int CHACHA_IDX_W       = 4;

  typedef logic [CHACHA_BLOCK_W-1:0] chacha_block_t;
  typedef logic [CHACHA_WORD_W-1:0]  chacha_word_t;
  typedef logic [CHACHA_IDX_W-1:0]   chacha_idx_t;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  // Word k of a block lives at bits [32k+31:32k].
  function automatic chacha_word_t word_of(input chacha_block_t blk, input chacha_idx_t idx);
    return blk[{idx, 5'd0} +: CHACHA_WORD_W];
  endfunction

endpackage

// File: rtl/chacha_block_buf.sv
// Two-entry block store: active block being drained plus one shadow block queued behind it.
// Latency: a push lands in active (if empty after any same-cycle pop) or shadow on the next edge.
// Backpressure: caller must not push while shadow_full_o; pop promotes shadow to active with no bubble.
module chacha_block_buf
  import chacha_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  chacha_block_t push_data_i,
  input  logic          push_last_i,
  input  logic          pop_i,
  output chacha_block_t active_o,
  output logic          active_last_o,
  output logic          active_full_o,
  output logic          shadow_full_o
);

  chacha_block_t active_q, active_d;
  chacha_block_t shadow_q, shadow_d;
  logic          active_last_q, active_last_d;
  logic          shadow_last_q, shadow_last_d;
  logic          active_full_q, active_full_d;
  logic          shadow_full_q, shadow_full_d;

  // Next-state: apply the pop first, then place any push into whichever slot is free afterwards.
  always_comb begin
    active_d      = active_q;
    active_last_d = active_last_q;
    active_full_d = active_full_q;
    shadow_d      = shadow_q;
    shadow_last_d = shadow_last_q;
    shadow_full_d = shadow_full_q;

    if (pop_i) begin
      if (shadow_full_q) begin
        active_d      = shadow_q;
        active_last_d = shadow_last_q;
        shadow_full_d = 1'b0;
      end else begin
        active_full_d = 1'b0;
      end
    end

    if (push_i) begin
      if (!active_full_d) begin
        active_d      = push_data_i;
        active_last_d = push_last_i;
        active_full_d = 1'b1;
      end else begin
        shadow_d      = push_data_i;
        shadow_last_d = push_last_i;
        shadow_full_d = 1'b1;
      end
    end
  end

  // Storage registers; reset empties both slots and clears held data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q      <= '0;
      active_last_q <= 1'b0;
      active_full_q <= 1'b0;
      shadow_q      <= '0;
      shadow_last_q <= 1'b0;
      shadow_full_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      active_last_q <= active_last_d;
      active_full_q <= active_full_d;
      shadow_q      <= shadow_d;
      shadow_last_q <= shadow_last_d;
      shadow_full_q <= shadow_full_d;
    end
  end

  assign active_o      = active_q;
  assign active_last_o = active_last_q;
  assign active_full_o = active_full_q;
  assign shadow_full_o = shadow_full_q;

endmodule

// File: rtl/chacha_block_serializer.sv
// Serializes 512-bit ChaCha blocks into a 32-bit AXI4-Stream with packet framing (tlast).
// Latency: block accepted at edge N with the serializer idle -> word 0 valid right after edge N.
// Backpressure: tready stalls hold tdata/tlast; shadow fills, then s_block_ready drops (flag-driven only).
module chacha_block_serializer
  import chacha_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int WORDS_PER_BLOCK   = 16,
  parameter int BLOCKS_PER_PACKET = 4
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] s_block_data,
  input  logic                                  s_block_valid,
  output logic                                  s_block_ready,
  input  logic                                  s_block_last,
  output logic [DATA_WIDTH-1:0]                 m00_axis_tdata,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tlast,
  output logic                                  busy
);

  localparam chacha_idx_t LAST_IDX = CHACHA_IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [15:0] LAST_BLK = 16'(BLOCKS_PER_PACKET - 1);

  ser_state_e    state_q, state_d;
  chacha_idx_t   idx_q, idx_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;

  chacha_block_t active_blk;
  logic          active_last;
  logic          active_full;
  logic          shadow_full;

  logic          push;
  logic          pop;
  logic          tvalid;
  logic          tlast;
  chacha_word_t  tdata;
  logic          hs;

  // Ready depends only on the shadow flag, never on downstream tready.
  assign s_block_ready = !shadow_full;
  assign push          = s_block_valid && s_block_ready;

  chacha_block_buf u_buf (
    .clk_i         (m00_axis_aclk),
    .rst_ni        (m00_axis_aresetn),
    .push_i        (push),
    .push_data_i   (s_block_data),
    .push_last_i   (s_block_last),
    .pop_i         (pop),
    .active_o      (active_blk),
    .active_last_o (active_last),
    .active_full_o (active_full),
    .shadow_full_o (shadow_full)
  );

  // FSM next state, word index, packet count and stream outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    tvalid    = 1'b0;
    tdata     = '0;
    tlast     = 1'b0;
    hs        = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      SER_IDLE: begin
        // Active is empty here; a push goes straight into it.
        if (push || shadow_full) state_d = SER_STREAM;
      end
      SER_STREAM: begin
        tvalid = 1'b1;
        tdata  = word_of(active_blk, idx_q);
        tlast  = (idx_q == LAST_IDX) && ((pkt_cnt_q == LAST_BLK) || active_last);
        hs     = m00_axis_tready;
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            pop       = 1'b1;
            idx_d     = '0;
            pkt_cnt_d = tlast ? 16'd0 : pkt_cnt_q + 16'd1;
            // Stay streaming if a block is queued or arriving on this same edge.
            if (!shadow_full && !push) state_d = SER_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  // State, index and packet counter registers; reset aborts any in-flight packet.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q   <= SER_IDLE;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m00_axis_tvalid = tvalid;
  assign m00_axis_tdata  = tdata;
  assign m00_axis_tlast  = tlast;
  assign busy            = active_full || shadow_full;

endmodule

// File: tb/tb_chacha_block_serializer.sv
module tb_chacha_block_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  // Default-parameter instance (4 blocks per packet)
  logic [511:0] s_data;
  logic         s_valid, s_last, s_ready;
  logic [31:0]  tdata;
  logic         tvalid, tready, tlast, busy;

  // Single-block-packet instance
  logic [511:0] d1_data;
  logic         d1_valid, d1_last, d1_ready;
  logic [31:0]  d1_tdata;
  logic         d1_tvalid, d1_tready, d1_tlast, d1_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0]  exp_q[$];
  int           held = 0;
  int           mcnt = 0;
  logic [31:0]  blk_base[8];
  logic         blk_last[8];
  int           vcyc;

  always #5 clk = ~clk;

  chacha_block_serializer u_dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .s_block_data     (s_data),
    .s_block_valid    (s_valid),
    .s_block_ready    (s_ready),
    .s_block_last     (s_last),
    .m00_axis_tdata   (tdata),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tready  (tready),
    .m00_axis_tlast   (tlast),
    .busy             (busy)
  );

  chacha_block_serializer #(.BLOCKS_PER_PACKET(1)) u_dut1 (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .s_block_data     (d1_data),
    .s_block_valid    (d1_valid),
    .s_block_ready    (d1_ready),
    .s_block_last     (d1_last),
    .m00_axis_tdata   (d1_tdata),
    .m00_axis_tvalid  (d1_tvalid),
    .m00_axis_tready  (d1_tready),
    .m00_axis_tlast   (d1_tlast),
    .busy             (d1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [31:0] base);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = base + 32'(k);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference framing: tlast on word 15 when the 4th block of a packet or a last-flagged block.
  task automatic push_model(input logic [31:0] base, input logic last);
    logic end_pkt;
    end_pkt = (mcnt == 3) || last;
    for (int k = 0; k < 16; k++)
      exp_q.push_back({(k == 15) && end_pkt, base + 32'(k)});
    mcnt = end_pkt ? 0 : mcnt + 1;
  endtask

  // Offer n blocks from blk_base/blk_last as fast as accepted, drain with the given tready mode
  // (0: always ready, 1: 10 cycles on / 10 off), checking every cycle against the model.
  task automatic run_blocks(input int n, input int mode, input string tag, output int valid_cycles);
    int          nxt, cyc, wc;
    logic        hs, acc, stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    nxt = 0; cyc = 0; wc = 0; valid_cycles = 0;
    stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
    while ((nxt < n || held > 0) && cyc < 2000) begin
      if (nxt < n) begin
        s_valid = 1'b1; s_data = mk(blk_base[nxt]); s_last = blk_last[nxt];
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      tready = (mode == 0) ? 1'b1 : (((cyc / 10) % 2) == 0);
      chk({tag, " ready"}, 32'(s_ready), 32'(held < 2));
      chk({tag, " busy"}, 32'(busy), 32'(held > 0));
      chk({tag, " tvalid"}, 32'(tvalid), 32'(held > 0));
      if (tvalid) begin
        valid_cycles++;
        e = (exp_q.size() > 0) ? exp_q[0] : 33'h1_DEAD_BEEF;
        chk({tag, " tdata"}, tdata, e[31:0]);
        chk({tag, " tlast"}, 32'(tlast), 32'(e[32]));
        if (stall_prev) begin
          chk({tag, " stall data"}, tdata, prev_data);
          chk({tag, " stall last"}, 32'(tlast), 32'(prev_last));
        end
      end
      hs = tvalid && tready;
      acc = s_valid && s_ready;
      stall_prev = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
      tick();
      cyc++;
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        wc++;
        if (wc == 16) begin wc = 0; held--; end
      end
      if (acc) begin
        push_model(blk_base[nxt], blk_last[nxt]);
        nxt++;
        held++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; tready = 1'b1;
    chk({tag, " finished in budget"}, 32'(cyc < 2000), 32'd1);
    chk({tag, " words left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; tready = 1'b1;
    d1_data = '0; d1_valid = 1'b0; d1_last = 1'b0; d1_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst tvalid", 32'(tvalid), 32'd0);
    chk("rst tlast", 32'(tlast), 32'd0);
    chk("rst tdata", tdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(s_ready), 32'd1);
    chk("rst d1 tvalid", 32'(d1_tvalid), 32'd0);
    chk("rst d1 ready", 32'(d1_ready), 32'd1);

    // Single block, one block per packet
    d1_valid = 1'b1; d1_data = mk(32'h0000_0100);
    tick();
    d1_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("single tvalid", 32'(d1_tvalid), 32'd1);
      chk("single tdata", d1_tdata, 32'h100 + 32'(k));
      chk("single tlast", 32'(d1_tlast), 32'(k == 15));
      tick();
    end
    chk("single tvalid after", 32'(d1_tvalid), 32'd0);
    chk("single busy after", 32'(d1_busy), 32'd0);

    // Four back-to-back blocks, no backpressure: 64 valid cycles, tlast on word 63
    for (int b = 0; b < 4; b++) begin
      blk_base[b] = 32'h1100_0000 + 32'(b << 8); blk_last[b] = 1'b0;
    end
    run_blocks(4, 0, "b2b", vcyc);
    chk("b2b valid cycles", 32'(vcyc), 32'd64);

    // Backpressure 10 on / 10 off
    for (int b = 0; b < 4; b++) begin
      blk_base[b] = 32'h2200_0000 + 32'(b << 8); blk_last[b] = 1'b0;
    end
    run_blocks(4, 1, "bp", vcyc);

    // s_block_last on the 2nd block restarts the packet count
    for (int b = 0; b < 6; b++) begin
      blk_base[b] = 32'h3300_0000 + 32'(b << 8); blk_last[b] = (b == 1);
    end
    run_blocks(6, 0, "lastflag", vcyc);

    // Async reset mid-block with the shadow full, packet count non-zero beforehand
    for (int b = 0; b < 2; b++) begin
      blk_base[b] = 32'h4400_0000 + 32'(b << 8); blk_last[b] = 1'b0;
    end
    run_blocks(2, 0, "pre-rst", vcyc);
    tready = 1'b0;
    s_valid = 1'b1; s_data = mk(32'h3000_0000);
    tick();
    s_data = mk(32'h3100_0000);
    tick();
    s_valid = 1'b0;
    chk("mid ready full", 32'(s_ready), 32'd0);
    chk("mid busy", 32'(busy), 32'd1);
    tready = 1'b1;
    repeat (7) tick();
    chk("mid word7", tdata, 32'h3000_0007);
    #2 rst_n = 1'b0;
    #1;
    chk("arst tvalid", 32'(tvalid), 32'd0);
    chk("arst tlast", 32'(tlast), 32'd0);
    chk("arst tdata", tdata, 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst ready", 32'(s_ready), 32'd1);
    #3 rst_n = 1'b1;
    held = 0; mcnt = 0; exp_q.delete();
    tick();
    for (int b = 0; b < 4; b++) begin
      blk_base[b] = 32'hA5A5_0000 + 32'(b << 8); blk_last[b] = 1'b0;
    end
    run_blocks(4, 0, "post-rst", vcyc);

    // New block offered on the same edge as the word-15 handshake, shadow empty
    tready = 1'b1;
    s_valid = 1'b1; s_data = mk(32'h5000_0000); s_last = 1'b0;
    tick();
    s_valid = 1'b0;
    repeat (15) tick();
    chk("edge w15 data", tdata, 32'h5000_000F);
    chk("edge w15 tlast", 32'(tlast), 32'd0);
    chk("edge ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data = mk(32'h5100_0000); s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    chk("edge next tvalid", 32'(tvalid), 32'd1);
    chk("edge next w0", tdata, 32'h5100_0000);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("edge next word", tdata, 32'h5100_0000 + 32'(k));
    end
    chk("edge next tlast", 32'(tlast), 32'd1);
    tick();
    chk("edge drained tvalid", 32'(tvalid), 32'd0);
    chk("edge drained busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
